shift_add_mul_ctrl: RTL and testbench

//  Sequential shift-and-add multiplier controller and datapath. It replaces the flat
//  4x4 AND-array/FA multiplier where area matters.

---
 rtl/mul_pkg.sv | 8 +
 rtl/rca_nb.sv | 23 ++
 rtl/shift_add_mul_ctrl.sv | 103 ++++++++++
 tb/tb_shift_add_mul_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/rca_nb.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
module rca_nb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential unsigned multiplier: one adder reused over WIDTH steps per operation,
// with a start/ready/done handshake toward the host.
module shift_add_mul_ctrl
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_x,
  input  logic [WIDTH-1:0]   i_y,
  output logic               o_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned        CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [WIDTH-1:0]   r_mcand;
  // The extra carry bit of the accumulator is always 0 after the shift, so it is not stored.
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_step;
  logic [2*WIDTH-1:0] r_product;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_accept   = o_ready & i_start;
  assign w_last     = (r_state == ST_RUN) && (r_step == LAST_STEP);
  assign w_addend   = r_acc[0] ? r_mcand : '0;
  assign w_acc_next = {w_cout, w_sum, r_acc[WIDTH-1:1]};
  assign o_product  = r_product;

  rca_nb #(
    .WIDTH(WIDTH)
  ) u_rca (
    .i_a   (r_acc[2*WIDTH-1:WIDTH]),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_s   (w_sum),
    .o_cout(w_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_RUN;
      ST_RUN:  if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = i_start ? ST_RUN : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      ST_IDLE: o_ready = 1'b1;
      ST_RUN:  o_busy  = 1'b1;
      ST_DONE: begin
        o_ready = 1'b1;
        o_done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_step    <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand <= i_x;
      r_acc   <= {{WIDTH{1'b0}}, i_y};
      r_step  <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc  <= w_acc_next;
      r_step <= r_step + CNT_W'(1);
      if (w_last) r_product <= w_acc_next;
    end
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Self-checking bench for shift_add_mul_ctrl: directed scenarios, exhaustive pairs and a
// randomized scoreboard run against plain a*b arithmetic.
module tb_shift_add_mul_ctrl;

  localparam int unsigned W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [W-1:0]     x = '0;
  logic [W-1:0]     y = '0;
  logic             ready;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int               n_vec = 0;
  int               n_err = 0;
  logic [2*W-1:0]   exp_q[$];

  shift_add_mul_ctrl #(
    .WIDTH(W)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_x      (x),
    .i_y      (y),
    .o_ready  (ready),
    .o_busy   (busy),
    .o_done   (done),
    .o_product(product)
  );

  always #5 clk = ~clk;

  // Drives one request from a negedge and returns at the negedge where done is seen.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                       output int nbusy, output logic [2*W-1:0] prod);
    x     = a;
    y     = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    prod = product;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++;
    if (product !== '0) begin
      n_err++; $display("FAIL reset_product: got %0d expected 0", product);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, nbusy;
    logic [2*W-1:0] p;
    do_op(4'd15, 4'd15, lat, nbusy, p);
    n_vec++;
    if (lat !== W) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", lat, W); end
    n_vec++;
    if (nbusy !== W) begin n_err++; $display("FAIL basic_busy: got %0d expected %0d", nbusy, W); end
    n_vec++;
    if (p !== 8'd225) begin n_err++; $display("FAIL basic_product: got %0d expected 225", p); end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_err++; $display("FAIL basic_pulse: got done=%b ready=%b expected done=0 ready=1", done, ready);
    end
  endtask

  task automatic test_zero_one();
    int lat, nbusy;
    logic [2*W-1:0] p;
    do_op(4'd0, 4'd9, lat, nbusy, p);
    n_vec++;
    if (p !== 8'd0 || lat !== W) begin
      n_err++; $display("FAIL zero_product: got %0d lat %0d expected 0 lat %0d", p, lat, W);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL zero_pulse: got done=%b expected 0", done); end
    do_op(4'd13, 4'd1, lat, nbusy, p);
    n_vec++;
    if (p !== 8'd13 || lat !== W) begin
      n_err++; $display("FAIL one_product: got %0d lat %0d expected 13 lat %0d", p, lat, W);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL one_pulse: got done=%b expected 0", done); end
  endtask

  task automatic test_back_to_back();
    int next_done = W + 1;
    int n_done    = 0;
    int guard     = 0;
    x     = 4'd3;
    y     = 4'd5;
    start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (busy) begin
        n_vec++;
        if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready: got %b expected 0", ready); end
      end
      if (done) begin
        n_done++;
        n_vec++;
        if (product !== 8'd15 || i !== next_done) begin
          n_err++;
          $display("FAIL b2b_done: got product %0d at %0d expected 15 at %0d", product, i, next_done);
        end
        next_done += W + 1;
      end
    end
    n_vec++;
    if (n_done !== 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", n_done); end
    start = 1'b0;
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (!ready) begin n_err++; $display("FAIL b2b_drain: got ready=0 expected 1"); end
  endtask

  task automatic test_ignore_during_run();
    int lat = 0;
    x     = 4'd7;
    y     = 4'd6;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    x     = W'($urandom);
    y     = W'($urandom);
    n_vec++;
    if (ready !== 1'b0 || product !== 8'd15) begin
      n_err++;
      $display("FAIL ignore_step1: got ready=%b product=%0d expected ready=0 product=15",
               ready, product);
    end
    @(negedge clk);
    start = 1'b0;
    x     = W'($urandom);
    y     = W'($urandom);
    n_vec++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL ignore_step2: got ready=%b expected 0", ready); end
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (product !== 8'd42) begin n_err++; $display("FAIL ignore_product: got %0d expected 42", product); end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || ready !== 1'b1) begin
      n_err++; $display("FAIL ignore_no_requeue: got busy=%b ready=%b expected 0 1", busy, ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, nbusy;
    logic [2*W-1:0] p;
    x     = 4'd9;
    y     = 4'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      n_err++;
      $display("FAIL abort_state: got ready=%b busy=%b done=%b product=%0d expected 1 0 0 0",
               ready, busy, done, product);
    end
    rst = 1'b0;
    do_op(4'd2, 4'd3, lat, nbusy, p);
    n_vec++;
    if (p !== 8'd6 || lat !== W) begin
      n_err++; $display("FAIL abort_reop: got %0d lat %0d expected 6 lat %0d", p, lat, W);
    end
  endtask

  task automatic test_exhaustive();
    int lat, nbusy;
    int n_acc = 0;
    int n_done = 0;
    int off = int'($urandom_range(0, 15));
    logic [2*W-1:0] p;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        int a = (ia + off) % 16;
        int b = (ib * 7 + off) % 16;
        do_op(W'(a), W'(b), lat, nbusy, p);
        n_acc++;
        if (lat == W) n_done++;
        n_vec++;
        if (p !== (2 * W)'(a * b)) begin
          n_err++; $display("FAIL exh_%0d_%0d: got %0d expected %0d", a, b, p, a * b);
        end
      end
    end
    n_vec++;
    if (n_done !== n_acc) begin
      n_err++; $display("FAIL exh_done_count: got %0d expected %0d", n_done, n_acc);
    end
  endtask

  task automatic test_random_scoreboard();
    logic prev_done = 1'b0;
    logic [2*W-1:0] e;
    for (int c = 0; c < 300 + 2 * W; c++) begin
      @(negedge clk);
      if (done) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_spurious_done: got done=1 expected no pending op");
        end else begin
          e = exp_q.pop_front();
          if (product !== e) begin
            n_err++; $display("FAIL rand_product: got %0d expected %0d", product, e);
          end
        end
      end
      n_vec++;
      if (busy !== ~ready || (done && prev_done)) begin
        n_err++;
        $display("FAIL rand_flags: got busy=%b ready=%b done=%b prev_done=%b", busy, ready, done,
                 prev_done);
      end
      prev_done = done;
      start = (c < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      x     = W'($urandom);
      y     = W'($urandom);
      if (ready && start) exp_q.push_back((2 * W)'(x) * (2 * W)'(y));
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_pending: got %0d outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_one();
    test_back_to_back();
    test_ignore_during_run();
    test_reset_mid_run();
    test_exhaustive();
    test_random_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
